// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset controller:
// FSM states, opcodes, ALU codes and datapath mux selects.
package mc_pkg;

   typedef enum logic [3:0] {
      START,
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECUTER,
      EXECUTEI,
      ALUWB,
      JAL,
      BEQ
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // alu_op is the coarse request from the FSM; FUNCT defers to funct3/funct7
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALU_OUT    = 2'b00;
   localparam logic [1:0] RES_READ_DATA  = 2'b01;
   localparam logic [1:0] RES_ALU_RESULT = 2'b10;

   localparam logic [1:0] SRCA_PC     = 2'b00;
   localparam logic [1:0] SRCA_OLD_PC = 2'b01;
   localparam logic [1:0] SRCA_RS1    = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode: turns the FSM's coarse alu_op plus the
// instruction funct fields into the 3-bit ALU operation.
module alu_decoder
   import mc_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   // funct7_5 only selects sub for register-register ops; addi reuses that bit as immediate
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alu_control = (funct7_5 && op5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle core: sequences fetch, decode, memory,
// ALU and write-back steps, stalling on mem_ready and flagging bad opcodes.
module multicycle_controller
   import mc_pkg::*;
#(
   parameter logic RESET_PC_WRITE = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       instr_done,
   output logic       illegal_op
);

   state_t     state;
   state_t     next_state;
   logic [1:0] alu_op;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= START;
      else        state <= next_state;
   end

   // Outputs are Moore apart from mem_ready gating and zero on pc_write
   always_comb begin
      next_state = state;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALU_OUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      case (state)
         START: begin
            pc_write   = RESET_PC_WRITE;
            next_state = FETCH;
         end
         FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU_RESULT;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) next_state = DECODE;
         end
         DECODE: begin
            alu_src_a = SRCA_OLD_PC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_R:         next_state = EXECUTER;
               OP_I:         next_state = EXECUTEI;
               OP_JAL:       next_state = JAL;
               OP_BEQ:       next_state = BEQ;
               default: begin
                  next_state = FETCH;
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) next_state = MEMWB;
         end
         MEMWB: begin
            result_src = RES_READ_DATA;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            next_state = FETCH;
         end
         MEMWRITE: begin
            mem_req    = 1'b1;
            mem_write  = 1'b1;
            adr_src    = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) next_state = FETCH;
         end
         EXECUTER: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_FUNCT;
            next_state = ALUWB;
         end
         EXECUTEI: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_op     = ALUOP_FUNCT;
            next_state = ALUWB;
         end
         ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            next_state = FETCH;
         end
         JAL: begin
            alu_src_a  = SRCA_OLD_PC;
            alu_src_b  = SRCB_FOUR;
            pc_write   = 1'b1;
            next_state = ALUWB;
         end
         BEQ: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_SUB;
            pc_write   = zero;
            instr_done = 1'b1;
            next_state = FETCH;
         end
         default: next_state = START;
      endcase
   end

   always_comb begin
      case (op)
         OP_SW:   imm_src = IMM_S;
         OP_BEQ:  imm_src = IMM_B;
         OP_JAL:  imm_src = IMM_J;
         default: imm_src = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .op5         (op[5]),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: walks each
// instruction class cycle by cycle against hand-written control vectors.
module tb_multicycle_controller;

   localparam logic [6:0] T_LW  = 7'b0000011;
   localparam logic [6:0] T_SW  = 7'b0100011;
   localparam logic [6:0] T_R   = 7'b0110011;
   localparam logic [6:0] T_I   = 7'b0010011;
   localparam logic [6:0] T_JAL = 7'b1101111;
   localparam logic [6:0] T_BEQ = 7'b1100011;
   localparam logic [6:0] T_BAD = 7'b1111111;

   logic       clk;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_write;
   logic       adr_src;
   logic       ir_write;
   logic       pc_write;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] imm_src;
   logic [2:0] alu_control;
   logic       instr_done;
   logic       illegal_op;

   int check_count = 0;
   int error_count = 0;

   logic [16:0] ctl_vec;
   assign ctl_vec = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                     result_src, alu_src_a, alu_src_b, alu_control, instr_done, illegal_op};

   multicycle_controller #(.RESET_PC_WRITE(1'b0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .op          (op),
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .mem_write   (mem_write),
      .adr_src     (adr_src),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .reg_write   (reg_write),
      .result_src  (result_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .imm_src     (imm_src),
      .alu_control (alu_control),
      .instr_done  (instr_done),
      .illegal_op  (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] ctl(input logic mreq, input logic mw, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] res, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] alu,
                                       input logic done, input logic ill);
      return {mreq, mw, adr, irw, pcw, rw, res, sa, sb, alu, done, ill};
   endfunction

   logic [16:0] v_fetch, v_fetch_stall, v_decode, v_aluwb, v_memadr, v_memread;
   logic [16:0] v_memwb, v_memwrite, v_memwrite_stall, v_jal, v_illegal;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input logic z, input logic rdy);
      op        = o;
      funct3    = f3;
      funct7_5  = f7;
      zero      = z;
      mem_ready = rdy;
   endtask

   // Settle, compare the whole control vector, then move to 1ns after the next edge
   task automatic expectCycle(input string tag, input logic [16:0] expected);
      #1;
      checkOutput(tag, {15'd0, ctl_vec}, {15'd0, expected});
      @(posedge clk);
      #1;
   endtask

   task automatic runAlu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [2:0] exp_alu);
      logic [1:0] sb;
      sb = (o == T_I) ? 2'b01 : 2'b00;
      applyStimulus(o, f3, f7, 1'b0, 1'b1);
      expectCycle({tag, "_fetch"}, v_fetch);
      expectCycle({tag, "_decode"}, v_decode);
      #1;
      checkOutput({tag, "_imm"}, {30'd0, imm_src}, 32'd0);
      expectCycle({tag, "_exec"}, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, sb, exp_alu, 0, 0));
      expectCycle({tag, "_aluwb"}, v_aluwb);
   endtask

   initial begin
      v_fetch          = ctl(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
      v_fetch_stall    = ctl(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
      v_decode         = ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0);
      v_aluwb          = ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
      v_memadr         = ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0);
      v_memread        = ctl(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
      v_memwb          = ctl(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0);
      v_memwrite       = ctl(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
      v_memwrite_stall = ctl(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
      v_jal            = ctl(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0);
      v_illegal        = ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 1, 1);

      rst_n = 1'b0;
      applyStimulus(T_R, 3'b000, 1'b0, 1'b0, 1'b1);
      #12;
      @(posedge clk);
      #1;
      checkOutput("in_reset", {15'd0, ctl_vec}, 32'd0);
      rst_n = 1'b1;
      expectCycle("start", 17'd0);

      runAlu("r_add", T_R, 3'b000, 1'b0, 3'b000);
      runAlu("r_sub", T_R, 3'b000, 1'b1, 3'b001);
      runAlu("addi_f7", T_I, 3'b000, 1'b1, 3'b000);
      runAlu("r_and", T_R, 3'b111, 1'b0, 3'b010);
      runAlu("ori", T_I, 3'b110, 1'b0, 3'b011);
      runAlu("r_slt", T_R, 3'b010, 1'b0, 3'b101);
      runAlu("r_f3_001", T_R, 3'b001, 1'b0, 3'b000);

      // lw: one fetch stall, then 3 stall cycles in MEMREAD
      applyStimulus(T_LW, 3'b010, 1'b0, 1'b0, 1'b0);
      expectCycle("lw_fetch_stall", v_fetch_stall);
      mem_ready = 1'b1;
      expectCycle("lw_fetch", v_fetch);
      expectCycle("lw_decode", v_decode);
      expectCycle("lw_memadr", v_memadr);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) expectCycle($sformatf("lw_memread_stall%0d", i), v_memread);
      mem_ready = 1'b1;
      expectCycle("lw_memread", v_memread);
      expectCycle("lw_memwb", v_memwb);

      applyStimulus(T_SW, 3'b010, 1'b0, 1'b0, 1'b1);
      expectCycle("sw_fetch", v_fetch);
      expectCycle("sw_decode", v_decode);
      #1;
      checkOutput("sw_imm", {30'd0, imm_src}, 32'd1);
      expectCycle("sw_memadr", v_memadr);
      expectCycle("sw_memwrite", v_memwrite);

      for (int z = 1; z >= 0; z--) begin
         applyStimulus(T_BEQ, 3'b000, z[0], z[0], 1'b1);
         expectCycle($sformatf("beq%0d_fetch", z), v_fetch);
         #1;
         checkOutput($sformatf("beq%0d_imm", z), {30'd0, imm_src}, 32'd2);
         expectCycle($sformatf("beq%0d_decode", z), v_decode);
         expectCycle($sformatf("beq%0d_beq", z),
                     ctl(0, 0, 0, 0, z[0], 0, 2'b00, 2'b10, 2'b00, 3'b001, 1, 0));
      end

      applyStimulus(T_JAL, 3'b000, 1'b0, 1'b0, 1'b1);
      expectCycle("jal_fetch", v_fetch);
      #1;
      checkOutput("jal_imm", {30'd0, imm_src}, 32'd3);
      expectCycle("jal_decode", v_decode);
      expectCycle("jal_jal", v_jal);
      expectCycle("jal_aluwb", v_aluwb);

      applyStimulus(T_BAD, 3'b000, 1'b0, 1'b0, 1'b1);
      expectCycle("bad_fetch", v_fetch);
      expectCycle("bad_decode", v_illegal);
      expectCycle("bad_next_fetch", v_fetch);
      expectCycle("bad_decode2", v_illegal);

      // Reset dropped while a store is stalled in MEMWRITE
      applyStimulus(T_SW, 3'b010, 1'b0, 1'b0, 1'b1);
      expectCycle("swr_fetch", v_fetch);
      expectCycle("swr_decode", v_decode);
      expectCycle("swr_memadr", v_memadr);
      mem_ready = 1'b0;
      expectCycle("swr_stall", v_memwrite_stall);
      #1;
      checkOutput("swr_stall_held", {15'd0, ctl_vec}, {15'd0, v_memwrite_stall});
      rst_n = 1'b0;
      #1;
      checkOutput("swr_mem_write_async", {31'd0, mem_write}, 32'd0);
      checkOutput("swr_all_async", {15'd0, ctl_vec}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("swr_in_reset", {15'd0, ctl_vec}, 32'd0);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      expectCycle("swr_start", 17'd0);
      expectCycle("swr_refetch", v_fetch);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I-subset core that replaces the single-cycle datapath. It sequences one shared instruction/data memory, the ALU, the register file, and the PC/IR/ALUOut registers across several cycles per instruction. It stalls on a memory ready handshake and flags unsupported opcodes.

## Interface
Parameters:
- RESET_PC_WRITE, 0, reserved. Must be 0. Kept so the parameter list matches the package.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  instruction[6:0] from the IR.
- funct3  in  3  instruction[14:12].
- funct7_5  in  1  instruction[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_req  out  1  memory access requested.
- mem_write  out  1  store strobe; only valid with mem_req.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the IR and the OldPC register.
- pc_write  out  1  load the PC from the result mux.
- reg_write  out  1  register file write enable.
- result_src  out  2  result mux select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- alu_src_b  out  2  ALU B select: 00 = rs2 register, 01 = imm_ext, 10 = constant 4.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- States: START, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ.
- START: all outputs 0. Next state is FETCH, unconditionally.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - ir_write and pc_write are both gated by mem_ready.
  - Stay in FETCH until mem_ready; then go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, add (precomputes the branch target into ALUOut). Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other opcode -> FETCH, with illegal_op=1 and instr_done=1 (treated as a NOP).
- MEMADR: alu_src_a=10, alu_src_b=01, add. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, adr_src=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next: FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Hold until mem_ready; in that cycle instr_done=1. Next: FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, funct decode. Next: ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, funct decode. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next: FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Next: ALUWB (writes rd = OldPC+4).
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero, instr_done=1. Next: FETCH.
- ALU decode. The FSM issues an alu_op of 00 (add), 01 (sub) or 10 (funct). For alu_op=10:
  - funct3 000: sub only when funct7_5=1 and op[5]=1 (R-type); otherwise add.
  - funct3 010 -> slt; 110 -> or; 111 -> and.
  - any other funct3 -> add.
- imm_src is decoded combinationally from op in every state: lw and opcode 0010011 -> 00, sw -> 01, beq -> 10, jal -> 11, anything else -> 00.
- Any output not listed for a state is 0 in that state.

## Timing
- Moore outputs decoded from the state register. The only Mealy terms are the mem_ready gating and zero on pc_write.
- Reset: the state is START while rst_n=0, so every output is 0 during reset and in the first cycle after release.
- Cycles per instruction with mem_ready tied high:
  - lw: 5
  - sw: 4
  - R-type and I-type ALU: 4
  - jal: 4
  - beq: 3
  - illegal opcode: 2
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs are held stable for the whole stall.
- Reset asserted mid-instruction: immediate return to START. No partial write is committed after rst_n falls.
- instr_done is never asserted in two consecutive cycles.

## Structure
- Shared package mc_pkg holds:
  - the state enum
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ)
  - ALU control codes
  - the mux select encodings for result_src, alu_src_a and alu_src_b
- One sub-module, alu_decoder: combinational, inputs alu_op/funct3/funct7_5/op5, output alu_control.
- imm_src decode stays inline.

## Test plan
- Reset release with mem_ready=1 and op=0110011:
  - cycle 0: START, all outputs 0
  - cycle 1: FETCH with ir_write=1 and pc_write=1
  - then DECODE, EXECUTER, ALUWB with reg_write=1 and instr_done=1
- lw with mem_ready low for 3 cycles in MEMREAD: 8 cycles from FETCH to instr_done; mem_req and adr_src=1 held for all 4 MEMREAD cycles.
- beq: zero=1 gives pc_write=1 in BEQ; zero=0 gives pc_write=0. Both cases return to FETCH after 3 cycles.
- R-type funct3=000, funct7_5=1 -> alu_control=001 in EXECUTER. The same funct3/funct7_5 with op=0010011 (addi) -> 000 in EXECUTEI.
- op=1111111 -> illegal_op and instr_done pulse in DECODE; the next state is FETCH; reg_write and mem_write are never asserted.
- rst_n dropped during MEMWRITE while mem_ready=0 -> mem_write falls asynchronously to 0, and the state is START after release.
